mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one signed 16x16 shift-add multiplier (n_mult) among NUM_REQ butterfly requesters.
//  Round-robin arbitration, valid/ready handshake on each requester, 2-stage registered pipeline.
//  Single result bus; each product is tagged with the requester ID. Sits between FFT stage butterflies and the multiplier.
// PARAMETERS
//  NUM_REQ  4  number of requesters, 2..16
//  ID_W     2  width of result tag; 2**ID_W >= NUM_REQ required
// PORTS
//  clk          in   1            rising-edge clock, single domain
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   NUM_REQ      per-requester operand valid
//  req_a        in   16*NUM_REQ   packed signed operand A; slice i = [16*i+15:16*i]
//  req_b        in   16*NUM_REQ   packed signed operand B, same packing
//  req_ready    out  NUM_REQ      one-hot accept strobe
//  res_valid    out  1            result valid
//  res_ready    in   1            downstream accepts result
//  res_product  out  32           signed product A*B
//  res_id       out  ID_W         index of the requester that issued the operands
//  busy         out  1            either pipeline stage holds data
// BEHAVIOUR
//  Reset: req_ready=0, res_valid=0, res_product=0, res_id=0, busy=0, RR pointer=0, both stage valids=0.
//  Reset is honoured at any time; in-flight operations are discarded, never completed.
//  Pipeline: S1 = operand regs {a,b,id,v1}; n_mult is combinational between S1 and S2; S2 = {product,id,v2} drives res_*.
//  Stall rule: adv2 = !v2 | res_ready; adv1 = !v1 | adv2. Both stages move together. No skid buffer.
//  Arbitration: when adv1=1 and |req_valid, grant the first asserted requester at or after the pointer, wrapping modulo NUM_REQ.
//  req_ready[g]=1 in that cycle only (combinational from req_valid, pointer, adv1); transfer = req_valid[g] & req_ready[g].
//  After a transfer to g, pointer <= (g+1) mod NUM_REQ; no transfer leaves the pointer unchanged.
//  Requesters hold req_valid and operands stable until accepted; withdrawal before acceptance is illegal (assertion).
//  Latency: accept at edge N -> res_valid=1 after edge N+1 when there is no backpressure. Throughput is 1 product/cycle.
//  Backpressure: while res_valid & !res_ready, res_product and res_id hold; S1 holds when full; req_ready stays 0 while adv1=0.
//  Simultaneous events: S2 drain and S1->S2 move and a new grant into S1 can occur on the same edge.
//  Arithmetic: full 32-bit two's-complement product, no truncation; -32768*-32768 = 0x40000000 exactly.
//  Order: results leave in acceptance order; res_id identifies the requester.
//  busy = v1 | v2.
// CONFIGURATION
//  MULT_SHARE_Q15_EN defined: adds output res_q15[15:0], registered in S2 with res_product.
//    res_q15 = sat16((product + 2**14) >>> 15); round half up, saturate to [-32768, 32767]; reset value 0.
//  MULT_SHARE_Q15_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1 Requester 1 only: a=3, b=-5, res_ready=1 -> req_ready[1] on the accept edge; 2 cycles later res_product=-15 (0xFFFFFFF1), res_id=1.
//  2 All 4 valid, held continuously, res_ready=1 -> grants 0,1,2,3,0,... on consecutive cycles; no bubbles; res_id sequence matches the grants.
//  3 Pointer=2, req_valid=4'b1001 -> grant 3, then 0; pointer wraps to 1.
//  4 Pipeline full with res_ready=0 for 3 cycles -> res_product and res_id stable; req_ready=0; release -> no loss, no duplicate, order kept.
//  5 Corners: -32768*-32768 -> 0x40000000; -32768*32767 -> 0xC0008000; 0*x -> 0. With Q15: first -> res_q15=32767 (saturated); 0x4000*0x4000 -> 0x2000.
//  6 rst_n low mid-stream with both stages full -> all outputs 0 immediately (async); after release, first grant goes to requester 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Shares one signed 16x16 shift-add multiplier among NUM_REQ requesters, round-robin, tagged results.
// Latency: operands accepted at edge N appear on res_* after edge N+1; one product per cycle.
// Backpressure: res_ready low freezes S2, a full S1 then holds and req_ready stays low (no skid buffer).
// Optional: define MULT_SHARE_Q15_EN to add the registered, rounded and saturated res_q15 output.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_product,
  output logic [ID_W-1:0]        res_id,
`ifdef MULT_SHARE_Q15_EN
  output logic [15:0]            res_q15,
`endif
  output logic                   busy
);

  // Signed shift-add multiply: bits 0..14 of b add shifted copies of a, bit 15 carries weight -2^15.
  function automatic logic signed [31:0] n_mult(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] ae;
    logic signed [31:0] acc;
    ae  = {{16{a[15]}}, a};
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      if (b[i]) acc = acc + (ae <<< i);
    end
    if (b[15]) acc = acc - (ae <<< 15);
    return acc;
  endfunction

`ifdef MULT_SHARE_Q15_EN
  // Q15 rescale: add half an LSB, arithmetic shift by 15, clamp to the 16-bit signed range.
  function automatic logic [15:0] q15_sat(input logic signed [31:0] p);
    logic signed [32:0] s;
    logic signed [17:0] sh;
    s  = {p[31], p} + 33'sd16384;
    sh = s[32:15];
    if (sh > 18'sd32767)       return 16'h7FFF;
    else if (sh < -18'sd32768) return 16'h8000;
    else                       return sh[15:0];
  endfunction
`endif

  logic [ID_W-1:0]    ptr;
  logic               v1, v2;
  logic signed [15:0] a1, b1;
  logic [ID_W-1:0]    id1;
  logic               adv1, adv2;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic               xfer;
  logic [15:0]        a_sel, b_sel;
  logic signed [31:0] mult_out;

  assign adv2     = !v2 || res_ready;
  assign adv1     = !v1 || adv2;
  assign xfer     = |(req_valid & req_ready);
  assign a_sel    = req_a[16*int'(gnt_idx) +: 16];
  assign b_sel    = req_b[16*int'(gnt_idx) +: 16];
  assign mult_out = n_mult(a1, b1);
  assign res_valid = v2;
  assign busy      = v1 | v2;

  // Round-robin pick: first valid requester at or after the pointer; ready only when S1 can take it.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
    // Gating with rst_n keeps req_ready low while reset is held.
    if (adv1 && gnt_found && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  // Stage 1 operand registers and the round-robin pointer, which moves only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      id1 <= '0;
      ptr <= '0;
    end else if (adv1) begin
      v1 <= xfer;
      if (xfer) begin
        a1  <= a_sel;
        b1  <= b_sel;
        id1 <= gnt_idx;
        ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Stage 2 result registers; they hold whenever downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2          <= 1'b0;
      res_product <= '0;
      res_id      <= '0;
`ifdef MULT_SHARE_Q15_EN
      res_q15     <= '0;
`endif
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        res_product <= mult_out;
        res_id      <= id1;
`ifdef MULT_SHARE_Q15_EN
        res_q15     <= q15_sat(mult_out);
`endif
      end
    end
  end

`ifndef SYNTHESIS
  logic [NUM_REQ-1:0] pend;

  // Remember which requesters were offering but not accepted last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= req_valid & ~req_ready;
  end

  // A pending request must stay valid until it is accepted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((pend & ~req_valid) == '0)
        else $error("requester dropped req_valid before acceptance: %b", pend & ~req_valid);
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: per-requester operand queues feed a driver,
// acceptances push expected results into a scoreboard, a monitor pops and compares.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] a_arr [4];
  logic [15:0] b_arr [4];
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_product;
  logic [1:0]  res_id;
  logic        busy;
`ifdef MULT_SHARE_Q15_EN
  logic [15:0] res_q15;
`endif

  assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  mult_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_product(res_product), .res_id(res_id),
`ifdef MULT_SHARE_Q15_EN
    .res_q15(res_q15),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] p;
    logic [15:0] q;
  } exp_t;

  exp_t        sb [$];
  int          glog [$];
  int          gedge [$];
  int          redge [$];
  logic [15:0] op_a [4][16];
  logic [15:0] op_b [4][16];
  logic [31:0] op_p [4][16];
  logic [15:0] op_q [4][16];
  int          wr [4];
  int          rd [4];
  logic [3:0]  acc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_op(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] p, input logic [15:0] q);
    op_a[r][wr[r]] = a;
    op_b[r][wr[r]] = b;
    op_p[r][wr[r]] = p;
    op_q[r][wr[r]] = q;
    wr[r]++;
  endtask

  function automatic bit ops_left();
    bit any = 1'b0;
    for (int i = 0; i < 4; i++) if (rd[i] < wr[i]) any = 1'b1;
    return any;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((ops_left() || sb.size() > 0 || busy) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout %s: ops/results still outstanding=%0d after %0d cycles, required 0", tag, sb.size(), n);
    end
  endtask

  task automatic clear_logs();
    glog.delete();
    gedge.delete();
    redge.delete();
  endtask

  // Driver: at each negedge record acceptances, after the edge advance queues and drive next operands.
  initial begin
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0; rd[i] = 0; a_arr[i] = '0; b_arr[i] = '0;
    end
    forever begin
      exp_t e;
      @(negedge clk);
      acc = '0;
      if (rst_n) begin
        for (int i = 0; i < 4; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.id = 2'(i);
            e.p  = op_p[i][rd[i]];
            e.q  = op_q[i][rd[i]];
            sb.push_back(e);
            glog.push_back(i);
            gedge.push_back(cyc + 1);
            acc[i] = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && rd[i] < wr[i]) rd[i]++;
        if (rd[i] < wr[i]) begin
          req_valid[i] = 1'b1;
          a_arr[i]     = op_a[i][rd[i]];
          b_arr[i]     = op_b[i][rd[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every result handshake pops the oldest expectation and compares.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got id=%0d product=0x%08h, required no result", res_id, res_product);
        end else begin
          e = sb.pop_front();
          chk("res_product", res_product, e.p);
          chk("res_id", 32'(res_id), 32'(e.id));
`ifdef MULT_SHARE_Q15_EN
          chk("res_q15", 32'(res_q15), 32'(e.q));
`endif
          redge.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_t2 [8];
    int exp_t4 [3];
    exp_t2 = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_t4 = '{1, 2, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_product", res_product, 32'h0);
    chk("rst_res_id", 32'(res_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // 1: requester 1 alone, 3 * -5
    clear_logs();
    push_op(1, 16'd3, 16'hFFFB, 32'hFFFFFFF1, 16'h0000);
    drain("t1");
    chk("t1_grant_count", 32'(glog.size()), 32'd1);
    chk("t1_grant_id", 32'(glog[0]), 32'd1);
    chk("t1_latency", 32'(redge[0] - gedge[0]), 32'd1);

    // 3: pointer at 2, requesters 3 and 0 -> 3 then 0, pointer wraps to 1
    clear_logs();
    push_op(3, 16'd5, 16'd6, 32'd30, 16'h0000);
    push_op(0, 16'hFFFE, 16'd3, 32'hFFFFFFFA, 16'h0000);
    drain("t3");
    chk("t3_grant0", 32'(glog[0]), 32'd3);
    chk("t3_grant1", 32'(glog[1]), 32'd0);

    // 2: all four held valid, two ops each; pointer now 1
    clear_logs();
    push_op(0, 16'd100, 16'd200, 32'h00004E20, 16'h0001);
    push_op(0, 16'hFFFF, 16'hFFFF, 32'h00000001, 16'h0000);
    push_op(1, 16'hFFF9, 16'd9, 32'hFFFFFFC1, 16'h0000);
    push_op(1, 16'd256, 16'd256, 32'h00010000, 16'h0002);
    push_op(2, 16'd1234, 16'hFFFE, 32'hFFFFF65C, 16'h0000);
    push_op(2, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 16'h7FFE);
    push_op(3, 16'hFED4, 16'hFED4, 32'h00015F90, 16'h0003);
    push_op(3, 16'd0, 16'hCFC7, 32'h00000000, 16'h0000);
    drain("t2");
    chk("t2_grant_count", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(glog[k]), 32'(exp_t2[k]));
      chk($sformatf("t2_no_bubble%0d", k), 32'(gedge[k] - gedge[0]), 32'(k));
    end

    // 4: stall with full pipeline for 3 cycles, then release
    clear_logs();
    res_ready = 1'b0;
    push_op(0, 16'd11, 16'd11, 32'd121, 16'h0000);
    push_op(1, 16'd12, 16'd12, 32'd144, 16'h0000);
    push_op(2, 16'd13, 16'd13, 32'd169, 16'h0000);
    repeat (5) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(res_valid), 32'h1);
      chk("t4_hold_product", res_product, 32'd144);
      chk("t4_hold_id", 32'(res_id), 32'd1);
      chk("t4_req_ready", 32'(req_ready), 32'h0);
      chk("t4_busy", 32'(busy), 32'h1);
    end
    @(posedge clk); #2;
    res_ready = 1'b1;
    drain("t4");
    chk("t4_result_count", 32'(redge.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("t4_order%0d", k), 32'(glog[k]), 32'(exp_t4[k]));

    // 5: arithmetic corners
    clear_logs();
    push_op(0, 16'h8000, 16'h8000, 32'h40000000, 16'h7FFF);
    push_op(1, 16'h8000, 16'h7FFF, 32'hC0008000, 16'h8001);
    push_op(2, 16'd0, 16'd12345, 32'h00000000, 16'h0000);
    push_op(3, 16'h4000, 16'h4000, 32'h10000000, 16'h2000);
    drain("t5");
    chk("t5_result_count", 32'(redge.size()), 32'd4);

    // 6: async reset with both stages full, then first grant goes to requester 0
    clear_logs();
    res_ready = 1'b0;
    push_op(0, 16'd1, 16'd1, 32'd1, 16'h0000);
    push_op(1, 16'd2, 16'd2, 32'd4, 16'h0000);
    push_op(2, 16'd3, 16'd3, 32'd9, 16'h0000);
    push_op(3, 16'd4, 16'd4, 32'd16, 16'h0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_full_busy", 32'(busy), 32'h1);
    chk("t6_full_valid", 32'(res_valid), 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = wr[i];
    sb.delete();
    #1;
    chk("t6_rst_req_ready", 32'(req_ready), 32'h0);
    chk("t6_rst_res_valid", 32'(res_valid), 32'h0);
    chk("t6_rst_res_product", res_product, 32'h0);
    chk("t6_rst_res_id", 32'(res_id), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #2;
    clear_logs();
    push_op(0, 16'd2, 16'd3, 32'd6, 16'h0000);
    push_op(1, 16'hFFFC, 16'd4, 32'hFFFFFFF0, 16'h0000);
    push_op(2, 16'd7, 16'hFFF9, 32'hFFFFFFCF, 16'h0000);
    push_op(3, 16'hFFFF, 16'h7FFF, 32'hFFFF8001, 16'hFFFF);
    drain("t6");
    chk("t6_grant_count", 32'(glog.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("t6_grant%0d", k), 32'(glog[k]), 32'(k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
